// File: rtl/zed_io_pkg.sv
// rtl/zed_io_pkg.sv - shared source numbering, FSM encoding and ID helper for the interrupt arbiter
package zed_io_pkg;

    localparam int NSRC     = 13;
    localparam int ID_W     = 4;
    localparam int NSW      = 8;
    localparam int NBTN     = 5;
    localparam int SW_BASE  = 0;
    localparam int BTN_BASE = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_WAIT    = 2'd3
    } arb_state_t;

    // (base + step) modulo NSRC, for base < NSRC and step <= NSRC
    function automatic logic [ID_W-1:0] id_add(input logic [ID_W-1:0] base, input logic [ID_W:0] step);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + step;
        if (sum >= (ID_W+1)'(NSRC)) begin
            sum = sum - (ID_W+1)'(NSRC);
        end
        return sum[ID_W-1:0];
    endfunction

endpackage

// File: rtl/int_arbiter_if.sv
// rtl/int_arbiter_if.sv - vector presentation handshake between arbiter and interrupt consumer
interface int_arbiter_if;
    import zed_io_pkg::*;

    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic            irq_spurious;

    modport master (output irq_valid, output irq_id, output irq_spurious, input irq_ack);
    modport slave  (input irq_valid, input irq_id, input irq_spurious, output irq_ack);

endinterface

// File: rtl/int_arbiter_rr_pick.sv
// rtl/int_arbiter_rr_pick.sv - combinational fixed/rotating priority picker over 13 sources
module rr_pick
    import zed_io_pkg::*;
(
    input  logic [NSRC-1:0] pending,
    input  logic [ID_W-1:0] last_grant,
    input  logic            rr_mode,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    logic [ID_W-1:0] idx;

    assign any = |pending;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            idx = rr_mode ? id_add(last_grant, (ID_W+1)'(i + 1)) : ID_W'(i);
            if (pending[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - interrupt arbiter: pick, present, acknowledge, clear and wait for drop
module int_arbiter
    import zed_io_pkg::*;
#(
    parameter int          TIMEOUT   = 8,
    parameter logic [15:0] CNT_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [NSW-1:0]     int_switch_sts,
    input  logic [NBTN-1:0]    int_button_sts,
    input  logic [NSRC-1:0]    src_mask,
    input  logic               rr_mode,
    output logic [NSW-1:0]     int_switch_clr,
    output logic [NBTN-1:0]    int_button_clr,
    int_arbiter_if.master      irq,
    output logic               clr_timeout,
    output logic [15:0]        served_cnt
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t       state;
    logic [ID_W-1:0]  last_grant;
    logic [NSRC-1:0]  clr_q;
    logic [WCNT_W-1:0] wcnt;
    logic [NSRC-1:0]  raw_sts;
    logic [NSRC-1:0]  pending;
    logic [ID_W-1:0]  winner;
    logic             any;

    assign raw_sts = {int_button_sts, int_switch_sts};
    assign pending = raw_sts & ~src_mask;

    assign int_switch_clr = clr_q[SW_BASE +: NSW];
    assign int_button_clr = clr_q[BTN_BASE +: NBTN];

    rr_pick u_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .rr_mode    (rr_mode),
        .winner     (winner),
        .any        (any)
    );

    // Arbitration FSM; clear pulses and the spurious flag are single-cycle by default.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state            <= ST_IDLE;
            irq.irq_valid    <= 1'b0;
            irq.irq_id       <= '0;
            irq.irq_spurious <= 1'b0;
            clr_q            <= '0;
            clr_timeout      <= 1'b0;
            served_cnt       <= CNT_RESET;
            last_grant       <= ID_W'(NSRC - 1);
            wcnt             <= '0;
        end else begin
            clr_q            <= '0;
            irq.irq_spurious <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        irq.irq_id    <= winner;
                        irq.irq_valid <= 1'b1;
                        state         <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Acknowledge takes precedence over a coincident status drop.
                    if (irq.irq_ack) begin
                        irq.irq_valid <= 1'b0;
                        last_grant    <= irq.irq_id;
                        if (served_cnt != 16'hFFFF) begin
                            served_cnt <= served_cnt + 16'd1;
                        end
                        clr_q <= NSRC'(1) << irq.irq_id;
                        state <= ST_CLEAR;
                    end else if (!raw_sts[irq.irq_id]) begin
                        irq.irq_valid    <= 1'b0;
                        irq.irq_spurious <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    wcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!raw_sts[last_grant]) begin
                        state <= ST_IDLE;
                    end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                        clr_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
